// File: rtl/muldiv_pkg.sv
// ==================================================================
// muldiv_pkg : shared op encodings, FSM state type, latency helper
// Rev 1.0
// ==================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_LATENCY = DEFAULT_WIDTH + 1;

  // Cycles from the accepting edge to the cycle showing done and new HI/LO.
  function automatic int unsigned muldiv_latency(input int unsigned width);
    return width + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ==================================================================
// muldiv_step : one combinational shift-add / restoring-divide iteration
// Rev 1.0
// ==================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
    // When the trial subtract succeeds the true difference fits in WIDTH bits.
    diff    = rem_sh[WIDTH-1:0] - operand;
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        hi_next = diff;
        lo_next = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem_sh[WIDTH-1:0];
        lo_next = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ==================================================================
// muldiv_unit : iterative HI/LO multiply/divide; signed ops with MULDIV_SIGNED_EN
// Rev 1.0
// ==================================================================
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state, state_next;
  logic [CNT_W-1:0]   count;
  logic               is_div;
  logic               neg_hi, neg_lo;
  logic [WIDTH-1:0]   acc_hi, acc_lo, operand_r;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
  assign sign_a = is_signed & operand_a[WIDTH-1];
  assign sign_b = is_signed & operand_b[WIDTH-1];
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif

  assign mag_a = sign_a ? -operand_a : operand_a;
  assign mag_b = sign_b ? -operand_b : operand_b;

  // neg_lo flips the product (MULT) or quotient (DIV); neg_hi flips the remainder.
  assign prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix = neg_lo ? -acc_lo : acc_lo;
  assign rem_fix  = neg_hi ? -acc_hi : acc_hi;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand_r),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (start && !op[1]) state_next = ST_RUN;
      ST_RUN:  if (count == CNT_W'(WIDTH-1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      is_div    <= 1'b0;
      neg_hi    <= 1'b0;
      neg_lo    <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_r <= '0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                acc_hi    <= '0;
                acc_lo    <= mag_b;
                operand_r <= mag_a;
                is_div    <= 1'b0;
                neg_lo    <= sign_a ^ sign_b;
                neg_hi    <= 1'b0;
                count     <= '0;
              end
              OP_DIV: begin
                acc_hi    <= '0;
                acc_lo    <= mag_a;
                operand_r <= mag_b;
                is_div    <= 1'b1;
                // Divide by zero keeps the all-ones quotient unsigned.
                neg_lo    <= (sign_a ^ sign_b) & (|operand_b);
                neg_hi    <= sign_a;
                count     <= '0;
              end
              OP_MTHI: hi <= operand_a;
              OP_MTLO: lo <= operand_a;
            endcase
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
        end
        ST_FIX: begin
          done <= 1'b1;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ==================================================================
// tb_muldiv_unit : directed + random checks of muldiv_unit against an arithmetic model
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = int'(muldiv_latency(W));
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         is_signed = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted operation, from plain arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s);
    logic           sg;
    logic [2*W-1:0] p;
    longint         sx, sy;
    sg = s & SIGNED_EN;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        if (sg) p = 64'(sx * sy);
        else    p = {32'b0, x} * {32'b0, y};
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
      end
      2'b01: begin
        if (y == '0) begin
          m_lo = '1;
          m_hi = x;
        end else if (sg) begin
          m_lo = W'(sx / sy);
          m_hi = W'(sx % sy);
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      2'b10: m_hi = x;
      default: m_lo = x;
    endcase
  endtask

  task automatic run_mt(input string tag, input logic [1:0] o, input logic [W-1:0] x);
    op = o; operand_a = x; operand_b = $urandom; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    model(o, x, '0, 1'b0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask

  // Starts MULT/DIV, optionally injects a start at cycle inject_at while busy.
  task automatic run_md(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic s, input int inject_at);
    int           cyc;
    bit           changed;
    logic [W-1:0] hold_hi, hold_lo;
    op = o; operand_a = x; operand_b = y; is_signed = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    hold_hi = hi;
    hold_lo = lo;
    model(o, x, y, s);
    check({tag, " busy"}, 64'(busy), 64'd1);
    cyc = 0;
    changed = 1'b0;
    while (!done && cyc < LAT + 10) begin
      if (cyc == inject_at) begin
        start = 1'b1; op = 2'b11; operand_a = 32'hDEAD_BEEF; operand_b = 32'h7;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
      if (!done && (hi !== hold_hi || lo !== hold_lo)) changed = 1'b1;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(LAT));
    check({tag, " held"}, 64'(changed), 64'd0);
    check({tag, " busy@done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    bit           saw_done;
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;

    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post-reset idle", 64'(busy), 64'd0);

    run_md("mult max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    run_md("div by zero", 2'b01, 32'd100, 32'd0, 1'b0, -1);
    run_md("div -7/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
    run_md("div ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    run_md("mult neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, -1);

    run_mt("mthi", 2'b10, 32'h1234_5678);
    run_md("mult 3x4 inject", 2'b00, 32'd3, 32'd4, 1'b0, 10);
    run_md("b2b 5x6", 2'b00, 32'd5, 32'd6, 1'b0, -1);
    run_mt("mtlo", 2'b11, 32'hCAFE_F00D);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(8, 28);
      if (ro[1]) run_mt("rand mt", ro, rx);
      else       run_md("rand md", ro, rx, ry, 1'($urandom_range(0, 1)), -1);
    end

    op = 2'b01; operand_a = 32'd1000; operand_b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("pre-reset busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst hi", 64'(hi), 64'(m_hi));
    check("async rst lo", 64'(lo), 64'(m_lo));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(posedge clock); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no done after rst", 64'(saw_done), 64'd0);
    run_md("after rst", 2'b00, 32'h0001_0001, 32'h0000_FFFF, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
